custom_clock_config_sequencer: RTL and testbench

CUSTOM_CLOCK_CONFIG_SEQUENCER -- requirements
Module: custom_clock_config_sequencer

---
 rtl/custom_clock_config_sequencer.sv | 120 ++++++++++++
 tb/tb_custom_clock_config_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/custom_clock_config_sequencer.sv
// Sequences phase-length reconfiguration of a downstream clock generator: the generator
// is disabled and allowed to settle low before new high/low lengths are applied.
module custom_clock_config_sequencer #(
    parameter int CYCLE_WIDTH    = 16,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEFAULT_CYCLES = 1
) (
    input  logic                   clk_in,
    input  logic                   arst_n,
    input  logic                   run,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [CYCLE_WIDTH-1:0] cfg_high_cycles,
    input  logic [CYCLE_WIDTH-1:0] cfg_low_cycles,
    input  logic                   gen_clk,
    output logic                   gen_enable,
    output logic [CYCLE_WIDTH-1:0] gen_high_cycles,
    output logic [CYCLE_WIDTH-1:0] gen_low_cycles,
    output logic                   busy,
    output logic                   cfg_error
);
    typedef enum logic [1:0] {IDLE, RUNNING, DRAIN, APPLY} state_t;

    localparam int                      CNT_W       = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CNT_W-1:0]        SETTLE      = CNT_W'(SETTLE_CYCLES);
    localparam logic [CYCLE_WIDTH-1:0]  DEFAULT_VAL = CYCLE_WIDTH'(DEFAULT_CYCLES);

    state_t                 state, state_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   pending;
    logic [CYCLE_WIDTH-1:0] pend_high, pend_low;
    logic                   xfer, xfer_bad, xfer_ok;
    logic                   load_cfg, capture_cfg, apply_pend;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign cfg_ready  = (state == IDLE) || (state == RUNNING);
    assign gen_enable = (state == RUNNING);
    assign busy       = (state == DRAIN) || (state == APPLY);
    assign xfer       = cfg_valid && cfg_ready;
    assign xfer_bad   = xfer && ((cfg_high_cycles == '0) || (cfg_low_cycles == '0));
    assign xfer_ok    = xfer && !xfer_bad;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        load_cfg    = 1'b0;
        capture_cfg = 1'b0;
        apply_pend  = 1'b0;
        case (state)
            IDLE: begin
                load_cfg = xfer_ok;
                if (run) state_next = RUNNING;
            end
            RUNNING: begin
                // A new config while running always goes through the drain, even if run drops
                if (xfer_ok) begin
                    capture_cfg = 1'b1;
                    state_next  = DRAIN;
                end else if (!run) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (gen_clk) begin
                    cnt_next = '0;
                end else if (sat_inc(cnt) >= SETTLE) begin
                    cnt_next   = '0;
                    state_next = APPLY;
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
            APPLY: begin
                apply_pend = pending;
                state_next = run ? RUNNING : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cfg_error <= xfer_bad;
            if (capture_cfg)         pending <= 1'b1;
            else if (state == APPLY) pending <= 1'b0;
        end
    end

    // Applied lengths only move in IDLE or on the APPLY exit edge, never while enabled
    always_ff @(posedge clk_in or negedge arst_n) begin
        if (!arst_n) begin
            gen_high_cycles <= DEFAULT_VAL;
            gen_low_cycles  <= DEFAULT_VAL;
        end else if (load_cfg) begin
            gen_high_cycles <= cfg_high_cycles;
            gen_low_cycles  <= cfg_low_cycles;
        end else if (apply_pend) begin
            gen_high_cycles <= pend_high;
            gen_low_cycles  <= pend_low;
        end
    end

    always_ff @(posedge clk_in) begin
        if (capture_cfg) begin
            pend_high <= cfg_high_cycles;
            pend_low  <= cfg_low_cycles;
        end
    end

endmodule

// File: tb/tb_custom_clock_config_sequencer.sv
// Directed bench for custom_clock_config_sequencer with a per-cycle expected-output queue.
module tb_custom_clock_config_sequencer;
    logic        clk_in = 1'b0;
    logic        arst_n;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_high_cycles;
    logic [15:0] cfg_low_cycles;
    logic        gen_clk;
    logic        gen_enable;
    logic [15:0] gen_high_cycles;
    logic [15:0] gen_low_cycles;
    logic        busy;
    logic        cfg_error;

    typedef struct packed {
        logic        en;
        logic        bsy;
        logic        rdy;
        logic        err;
        logic [15:0] hi;
        logic [15:0] lo;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    custom_clock_config_sequencer dut (
        .clk_in(clk_in),
        .arst_n(arst_n),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_high_cycles(cfg_high_cycles),
        .cfg_low_cycles(cfg_low_cycles),
        .gen_clk(gen_clk),
        .gen_enable(gen_enable),
        .gen_high_cycles(gen_high_cycles),
        .gen_low_cycles(gen_low_cycles),
        .busy(busy),
        .cfg_error(cfg_error)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_now(input string tag, input exp_t e);
        chk({tag, ".gen_enable"}, 32'(gen_enable),      32'(e.en));
        chk({tag, ".busy"},       32'(busy),            32'(e.bsy));
        chk({tag, ".cfg_ready"},  32'(cfg_ready),       32'(e.rdy));
        chk({tag, ".cfg_error"},  32'(cfg_error),       32'(e.err));
        chk({tag, ".gen_high"},   32'(gen_high_cycles), 32'(e.hi));
        chk({tag, ".gen_low"},    32'(gen_low_cycles),  32'(e.lo));
    endtask

    task automatic push(input logic en, input logic bsy, input logic rdy, input logic err,
                        input logic [15:0] hi, input logic [15:0] lo);
        exp_t e;
        e.en = en; e.bsy = bsy; e.rdy = rdy; e.err = err; e.hi = hi; e.lo = lo;
        sb.push_back(e);
    endtask

    // One clock edge; outputs are sampled 1 time unit later and compared with the queue head
    task automatic step(input string tag);
        exp_t e;
        @(posedge clk_in);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check_now(tag, e);
        end
    endtask

    // Transfer edge, three more low-sampled DRAIN edges, the APPLY cycle, then the exit state
    task automatic drain_apply(input string tag, input logic [15:0] ohi, input logic [15:0] olo,
                               input logic [15:0] nhi, input logic [15:0] nlo, input logic fin_en);
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, ohi, olo);
            step({tag, ".drain"});
            cfg_valid = 1'b0;
            gen_clk   = 1'b0;
        end
        push(1'b0, 1'b1, 1'b0, 1'b0, ohi, olo);
        step({tag, ".apply"});
        push(fin_en, 1'b0, 1'b1, 1'b0, nhi, nlo);
        step({tag, ".exit"});
    endtask

    initial begin
        exp_t rst_e;
        logic pat [7];
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        rst_e.en = 1'b0; rst_e.bsy = 1'b0; rst_e.rdy = 1'b1; rst_e.err = 1'b0;
        rst_e.hi = 16'd1; rst_e.lo = 16'd1;

        arst_n = 1'b0; run = 1'b0; cfg_valid = 1'b0;
        cfg_high_cycles = '0; cfg_low_cycles = '0; gen_clk = 1'b0;
        #12;
        check_now("reset", rst_e);

        // Release with run high: RUNNING after the first edge, default lengths
        run = 1'b1;
        arst_n = 1'b1;
        #1;
        check_now("release", rst_e);
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1);
        step("run_from_reset");

        // Drop run: drain with nothing pending and return to IDLE
        run = 1'b0;
        drain_apply("stop", 16'd1, 16'd1, 16'd1, 16'd1, 1'b0);

        // IDLE load 3/5 with run low, then start
        cfg_valid = 1'b1; cfg_high_cycles = 16'd3; cfg_low_cycles = 16'd5;
        push(1'b0, 1'b0, 1'b1, 1'b0, 16'd3, 16'd5);
        step("idle_load");
        cfg_valid = 1'b0; run = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd5);
        step("idle_start");

        // Zero field in RUNNING: one-cycle error, no other change
        cfg_valid = 1'b1; cfg_high_cycles = 16'd0; cfg_low_cycles = 16'd7;
        push(1'b1, 1'b0, 1'b1, 1'b1, 16'd3, 16'd5);
        step("zero_cfg");
        cfg_valid = 1'b0;
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd3, 16'd5);
        step("zero_cfg_after");

        // Reconfigure to 4/4 while running
        cfg_valid = 1'b1; cfg_high_cycles = 16'd4; cfg_low_cycles = 16'd4;
        drain_apply("to44", 16'd3, 16'd5, 16'd4, 16'd4, 1'b1);

        // 2/6 offered while gen_clk high; gen_clk stays high two more DRAIN cycles
        gen_clk = 1'b1;
        cfg_valid = 1'b1; cfg_high_cycles = 16'd2; cfg_low_cycles = 16'd6;
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd4);
        step("to26.xfer");
        cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd4);
            step("to26.high");
        end
        gen_clk = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd4);
            step("to26.low");
        end
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 16'd4);
        step("to26.apply");
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 16'd6);
        step("to26.exit");

        // gen_clk 0,0,1,0,0,0,0 in DRAIN: the 1 restarts the count
        cfg_valid = 1'b1; cfg_high_cycles = 16'd5; cfg_low_cycles = 16'd3;
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd6);
        step("glitch.xfer");
        cfg_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            gen_clk = pat[i];
            if (i < 6) push(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd6);
            else       push(1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 16'd6);
            step((i < 6) ? "glitch.drain" : "glitch.apply");
        end
        gen_clk = 1'b0;
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd5, 16'd3);
        step("glitch.exit");

        // Transfer with run low at the same edge: applied, then exit to IDLE
        cfg_valid = 1'b1; cfg_high_cycles = 16'd7; cfg_low_cycles = 16'd2; run = 1'b0;
        drain_apply("cfg_stop", 16'd5, 16'd3, 16'd7, 16'd2, 1'b0);

        // Reset during DRAIN with 9/9 pending
        run = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd7, 16'd2);
        step("rerun");
        cfg_valid = 1'b1; cfg_high_cycles = 16'd9; cfg_low_cycles = 16'd9;
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 16'd2);
        step("r9.xfer");
        cfg_valid = 1'b0;
        push(1'b0, 1'b1, 1'b0, 1'b0, 16'd7, 16'd2);
        step("r9.drain");
        #2;
        arst_n = 1'b0;
        #1;
        check_now("mid_reset", rst_e);
        run = 1'b0;
        #1;
        arst_n = 1'b1;
        push(1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1);
        step("post_reset_idle");
        run = 1'b1;
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1);
        step("post_reset_run");
        push(1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 16'd1);
        step("post_reset_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
